// File: rtl/imem_load_controller.sv
// Loads a byte stream into the writable IMEM bank as 16-bit words, high byte first,
// holding the CPU while the load runs and flagging bad lengths or aborts.
module imem_load_controller #(
    parameter int unsigned BASE_ADDR = 32,
    parameter int unsigned MAX_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_start_i,
    input  logic [5:0]  load_count_i,
    input  logic        load_abort_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  data_byte_i,
    output logic        byte_ready_o,
    output logic        imem_write_enable_o,
    output logic [5:0]  imem_write_select_o,
    output logic [15:0] imem_input_o,
    output logic        cpu_hold_o,
    output logic        load_done_o,
    output logic        load_error_o,
    output logic [5:0]  words_written_o
);

    localparam int unsigned AW = 6;
    localparam int unsigned CW = 6;
    localparam int unsigned DW = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HI_BYTE = 3'd1,
        LO_BYTE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] data_q,  data_d;
    logic [CW-1:0] ww_q,    ww_d;
    logic          err_q,   err_d;

    logic          count_ok;
    logic          last_word;

    assign count_ok  = (load_count_i != '0) && (32'(load_count_i) <= MAX_WORDS);
    assign last_word = (ww_q + CW'(1)) == count_q;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= AW'(BASE_ADDR);
            data_q  <= '0;
            ww_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ww_q    <= ww_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ww_d    = ww_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    if (count_ok) begin
                        count_d = load_count_i;
                        addr_d  = AW'(BASE_ADDR);
                        ww_d    = '0;
                        err_d   = 1'b0;
                        state_d = HI_BYTE;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            HI_BYTE: begin
                if (load_abort_i) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (byte_valid_i) begin
                    data_d  = {data_byte_i, data_q[7:0]};
                    state_d = LO_BYTE;
                end
            end
            LO_BYTE: begin
                if (load_abort_i) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (byte_valid_i) begin
                    data_d  = {data_q[15:8], data_byte_i};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                ww_d = ww_q + CW'(1);
                // Address stays on the final word so it never leaves the bank
                if (!last_word) begin
                    addr_d = addr_q + AW'(1);
                end
                if (load_abort_i) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (last_word) begin
                    state_d = DONE;
                end else begin
                    state_d = HI_BYTE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode; write bus is driven only during WRITE
    always_comb begin
        byte_ready_o        = 1'b0;
        imem_write_enable_o = 1'b0;
        imem_write_select_o = '0;
        imem_input_o        = '0;
        cpu_hold_o          = 1'b0;
        load_done_o         = 1'b0;
        load_error_o        = err_q;
        words_written_o     = ww_q;
        unique case (state_q)
            HI_BYTE, LO_BYTE: begin
                byte_ready_o = 1'b1;
                cpu_hold_o   = 1'b1;
            end
            WRITE: begin
                imem_write_enable_o = 1'b1;
                imem_write_select_o = addr_q;
                imem_input_o        = data_q;
                cpu_hold_o          = 1'b1;
            end
            DONE: begin
                load_done_o = 1'b1;
                cpu_hold_o  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_imem_load_controller.sv
// Self-checking bench for imem_load_controller: table of load scenarios, reset
// corner cases, and randomized loads checked against a transaction-level model.
module tb_imem_load_controller;

    localparam int unsigned BASE = 32;
    localparam int unsigned MAXW = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [5:0]  load_count = '0;
    logic        load_abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  data_byte = '0;
    logic        byte_ready;
    logic        we;
    logic [5:0]  sel;
    logic [15:0] din;
    logic        hold;
    logic        done;
    logic        err;
    logic [5:0]  ww;

    imem_load_controller #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .load_start_i        (load_start),
        .load_count_i        (load_count),
        .load_abort_i        (load_abort),
        .byte_valid_i        (byte_valid),
        .data_byte_i         (data_byte),
        .byte_ready_o        (byte_ready),
        .imem_write_enable_o (we),
        .imem_write_select_o (sel),
        .imem_input_o        (din),
        .cpu_hold_o          (hold),
        .load_done_o         (done),
        .load_error_o        (err),
        .words_written_o     (ww)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        int cnt;
        int nab;      // bytes transferred before abort, -1 = no abort
        int gap;      // byte_valid asserted every gap cycles
        int restart;  // drive cycle of a stray LOAD_START, -1 = none
        int fixed;    // use the 12 34 AB CD byte pattern
        int exp_ww;
        int exp_err;
        int exp_done;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    wr_t        wq[$];
    logic [7:0] bytes[$];
    int         done_cnt = 0;
    logic       done_prev = 1'b0;
    int         model_ww = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Write/done monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (we) wq.push_back('{sel, din});
        if (done) done_cnt++;
        if (done_prev) check("hold_after_done", int'(hold), 0);
        done_prev = done;
    end

    task automatic run_load(input vec_t v, input string tag);
        int idx;
        int cyc;
        int w;
        int target;
        logic xfer;
        wq.delete();
        bytes.delete();
        done_cnt = 0;
        for (int i = 0; i < 2 * v.cnt; i++) bytes.push_back(8'($urandom_range(0, 255)));
        if (v.fixed != 0) begin
            bytes.delete();
            bytes.push_back(8'h12); bytes.push_back(8'h34);
            bytes.push_back(8'hAB); bytes.push_back(8'hCD);
        end
        @(negedge clk);
        load_start = 1'b1;
        load_count = 6'(v.cnt);
        @(posedge clk);
        if (v.cnt < 1 || v.cnt > int'(MAXW)) begin
            @(negedge clk);
            load_start = 1'b0;
            @(negedge clk);
            check({tag, "_hold_idle"}, int'(hold), 0);
        end else begin
            target = (v.nab >= 0) ? v.nab : 2 * v.cnt;
            idx = 0;
            cyc = 0;
            while (idx < target && cyc < 3000) begin
                @(negedge clk);
                byte_valid = ((cyc % v.gap) == 0);
                data_byte  = bytes[idx];
                load_start = (cyc == v.restart);
                load_count = 6'd5;
                #1;
                xfer = byte_valid && byte_ready;
                @(posedge clk);
                if (xfer) idx++;
                cyc++;
            end
            @(negedge clk);
            byte_valid = 1'b0;
            load_start = 1'b0;
            if (idx < target) check({tag, "_byte_timeout"}, idx, target);
            if (v.nab >= 0) begin
                load_abort = 1'b1;
                byte_valid = 1'b1;
                data_byte  = 8'hEE;
                @(posedge clk);
                @(negedge clk);
                load_abort = 1'b0;
                byte_valid = 1'b0;
            end
            w = 0;
            while (hold && w < 100) begin
                @(negedge clk);
                w++;
            end
            check({tag, "_idle_reached"}, int'(hold), 0);
            @(negedge clk);
        end
        check({tag, "_words_written"}, int'(ww), v.exp_ww);
        check({tag, "_error"}, int'(err), v.exp_err);
        check({tag, "_done_pulses"}, done_cnt, v.exp_done);
        check({tag, "_write_count"}, wq.size(),
              (v.cnt < 1 || v.cnt > int'(MAXW)) ? 0 : v.exp_ww);
        for (int i = 0; i < wq.size() && i < v.exp_ww; i++) begin
            check({tag, "_addr"}, int'(wq[i].a), int'(BASE) + i);
            check({tag, "_data"}, int'(wq[i].d), int'({bytes[2*i], bytes[2*i+1]}));
        end
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        tbl[0] = '{2,  -1, 1, -1, 1, 2,  0, 1};
        tbl[1] = '{0,  -1, 1, -1, 0, 2,  1, 0};
        tbl[2] = '{33, -1, 1, -1, 0, 2,  1, 0};
        tbl[3] = '{32, -1, 1, -1, 0, 32, 0, 1};
        tbl[4] = '{3,   3, 1, -1, 0, 1,  1, 0};
        tbl[5] = '{4,  -1, 3,  2, 0, 4,  0, 1};
        tbl[6] = '{1,   0, 1, -1, 0, 0,  1, 0};
        tbl[7] = '{5,   4, 2, -1, 0, 2,  1, 0};
        tbl[8] = '{1,  -1, 1, -1, 0, 1,  0, 1};
        tbl[9] = '{63, -1, 1, -1, 0, 1,  1, 0};

        #12;
        check("reset_outputs", int'({byte_ready, we, sel, din, hold, done, err, ww}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_load(tbl[i], $sformatf("vec%0d", i));
            model_ww = tbl[i].exp_ww;
        end

        // Asynchronous reset while waiting for the low byte
        @(negedge clk);
        load_start = 1'b1;
        load_count = 6'd2;
        @(negedge clk);
        load_start = 1'b0;
        byte_valid = 1'b1;
        data_byte  = 8'h5A;
        @(posedge clk);
        #2;
        check("pre_reset_in_lo_ready", int'(byte_ready), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({byte_ready, we, sel, din, hold, done, err, ww}), 0);
        byte_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        v = '{1, -1, 1, -1, 0, 1, 0, 1};
        run_load(v, "post_reset");
        model_ww = 1;

        // Randomized loads against the transaction-level model
        for (int r = 0; r < 12; r++) begin
            v.cnt     = $urandom_range(0, 40);
            v.gap     = $urandom_range(1, 3);
            v.restart = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : -1;
            v.fixed   = 0;
            v.nab     = -1;
            if (v.cnt >= 1 && v.cnt <= int'(MAXW) && $urandom_range(0, 1) == 1)
                v.nab = $urandom_range(0, 2 * v.cnt - 1);
            if (v.cnt < 1 || v.cnt > int'(MAXW)) begin
                v.exp_ww = model_ww; v.exp_err = 1; v.exp_done = 0;
            end else if (v.nab >= 0) begin
                v.exp_ww = v.nab / 2; v.exp_err = 1; v.exp_done = 0;
            end else begin
                v.exp_ww = v.cnt; v.exp_err = 0; v.exp_done = 1;
            end
            run_load(v, $sformatf("rnd%0d", r));
            model_ww = v.exp_ww;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_load_controller.md
IMEM_LOAD_CONTROLLER -- requirements
Module: _IMEM_LoadController

Interface
REQ-001 Parameter BASE_ADDR, default 32, SHALL set the first IMEM write address (start of the writable instruction bank).
REQ-002 Parameter MAX_WORDS, default 32, SHALL set the largest accepted load length in words.
REQ-003 Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 LOAD_START  input  1  SHALL be a single-cycle request to begin a load.
REQ-006 LOAD_COUNT  input  6  SHALL give the number of 16-bit words to load; sampled only with LOAD_START.
REQ-007 LOAD_ABORT  input  1  SHALL be a level request to abandon the current load.
REQ-008 BYTE_VALID  input  1  SHALL flag that DATA_BYTE holds a valid byte.
REQ-009 DATA_BYTE  input  8  SHALL be the incoming instruction byte, high byte of each word first.
REQ-010 BYTE_READY  output  1  SHALL show that the controller accepts a byte this cycle.
REQ-011 IMEM_WRITE_ENABLE  output  1  SHALL drive the IMEM write enable.
REQ-012 IMEM_WRITE_SELECT  output  6  SHALL drive the IMEM write address.
REQ-013 IMEM_INPUT  output  16  SHALL drive the IMEM write data.
REQ-014 CPU_HOLD  output  1  SHALL stall the CPU while a load is in progress.
REQ-015 LOAD_DONE  output  1  SHALL pulse for one cycle when a load completes.
REQ-016 LOAD_ERROR  output  1  SHALL be the sticky error flag.
REQ-017 WORDS_WRITTEN  output  6  SHALL count words committed in the current or most recent load.

Function
REQ-018 States SHALL be IDLE, HI_BYTE, LO_BYTE, WRITE, DONE.
REQ-019 IDLE: on LOAD_START with 1 <= LOAD_COUNT <= MAX_WORDS the controller SHALL latch the count, set the address to BASE_ADDR, clear WORDS_WRITTEN and LOAD_ERROR, and enter HI_BYTE next cycle.
REQ-020 IDLE: on LOAD_START with LOAD_COUNT = 0 or > MAX_WORDS it SHALL set LOAD_ERROR, stay in IDLE, and issue no write.
REQ-021 BYTE_READY SHALL be 1 only in HI_BYTE and LO_BYTE; a byte transfers only in a cycle where BYTE_VALID = BYTE_READY = 1.
REQ-022 HI_BYTE: on transfer, DATA_BYTE SHALL load word bits [15:8] and the state SHALL go to LO_BYTE; without a transfer the state holds indefinitely.
REQ-023 LO_BYTE: on transfer, DATA_BYTE SHALL load bits [7:0] and the state SHALL go to WRITE.
REQ-024 WRITE: IMEM_WRITE_ENABLE SHALL be 1 for exactly this one cycle, with IMEM_WRITE_SELECT = current address and IMEM_INPUT = assembled word.
REQ-025 After WRITE, address and WORDS_WRITTEN SHALL increment by 1; if WORDS_WRITTEN then equals the latched count the state SHALL go to DONE, else to HI_BYTE.
REQ-026 Addresses SHALL never be below BASE_ADDR or above BASE_ADDR+MAX_WORDS-1 (default 32..63); no wrap-around SHALL occur.
REQ-027 DONE: LOAD_DONE SHALL be 1 for one cycle, then the state SHALL return to IDLE.
REQ-028 CPU_HOLD SHALL be 1 in HI_BYTE, LO_BYTE, WRITE and DONE, and 0 in IDLE.
REQ-029 IMEM_WRITE_ENABLE SHALL be 0 in all states other than WRITE.
REQ-030 LOAD_START outside IDLE SHALL be ignored.
REQ-031 LOAD_ABORT in HI_BYTE or LO_BYTE SHALL discard any partial word, set LOAD_ERROR, and return to IDLE next cycle with no write.
REQ-032 LOAD_ABORT in WRITE SHALL let the write complete, then go to IDLE with LOAD_ERROR set and no LOAD_DONE.
REQ-033 LOAD_ABORT and a byte transfer in the same cycle: abort SHALL win and the byte SHALL be dropped.
REQ-034 LOAD_ABORT in IDLE or DONE SHALL have no effect.

Reset
REQ-035 Reset low SHALL immediately force IDLE, all outputs 0, WORDS_WRITTEN 0, address BASE_ADDR, and the data register 0, including mid-load.
REQ-036 After Reset rises, the first LOAD_START SHALL be honoured on the first rising Clock edge.

Verification
REQ-037 LOAD_START with count 2, bytes 12,34,AB,CD -> writes 1234 at address 32, then ABCD at 33; LOAD_DONE pulses once; WORDS_WRITTEN = 2; CPU_HOLD drops the cycle after DONE.
REQ-038 LOAD_START with count 0, then with count 33 -> LOAD_ERROR = 1, no write, CPU_HOLD stays 0.
REQ-039 Count 32, full byte stream -> last write at address 63, WORDS_WRITTEN = 32, no write outside 32..63.
REQ-040 Count 3, LOAD_ABORT after the high byte of word 2 -> only address 32 written, LOAD_ERROR = 1, no LOAD_DONE.
REQ-041 BYTE_VALID gapped (valid every 3rd cycle) and LOAD_START re-pulsed mid-load -> same writes as gap-free, second start ignored.
REQ-042 Reset asserted in LO_BYTE -> all outputs 0 asynchronously; a new load of count 1 after release writes to address 32.
